// File: rtl/path_replay.sv
// path_replay: drains the direction stack left by the maze search into a local
// buffer, then replays the path from (0,0) forward, one move per handshake,
// checking bounds and that the path ends on DEST_ADDR.
//
// Handshake: a move is transferred on every rising edge where move_valid and
// move_ready are both 1; while move_valid=1 and move_ready=0 the move outputs
// hold steady. move_valid never depends on move_ready.
module path_replay #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEST_ADDR  = 2**8-1,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  empty,
  input  logic [1:0]            dout,
  output logic                  pop,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [1:0]            move_dir,
  output logic [3:0]            row,
  output logic [3:0]            colomn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [7:0]    DEST_POS   = 8'(DEST_ADDR);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic          fail_q, fail_d;

  logic [1:0]    path_mem_q [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_waddr;

  logic [1:0]    cur_dir;
  logic [3:0]    nxt_row;
  logic [3:0]    nxt_col;
  logic          oob;
  logic          in_emit;
  logic          accept;

  // Direction of the move pointed to by idx (only meaningful in EMIT).
  assign cur_dir = path_mem_q[idx_q];

  // Position after applying the current move; flags a step off the 16x16 grid.
  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q;
    oob     = 1'b0;
    case (cur_dir)
      2'd0: if (col_q == 4'hF) oob = 1'b1; else nxt_col = col_q + 4'd1;
      2'd1: if (row_q == 4'hF) oob = 1'b1; else nxt_row = row_q + 4'd1;
      2'd2: if (col_q == 4'h0) oob = 1'b1; else nxt_col = col_q - 4'd1;
      default: if (row_q == 4'h0) oob = 1'b1; else nxt_row = row_q - 4'd1;
    endcase
  end

  // Output decode; an out-of-bounds move is never offered downstream.
  always_comb begin
    in_emit    = (state_q == S_EMIT);
    move_valid = in_emit & ~oob;
    accept     = move_valid & move_ready;
    move_dir   = in_emit ? cur_dir : 2'd0;
    row        = move_valid ? nxt_row : row_q;
    colomn     = move_valid ? nxt_col : col_q;
    addr       = ADDR_WIDTH'({row, colomn});
    busy       = (state_q == S_DRAIN) | in_emit;
    done       = (state_q == S_FIN) & ({row_q, col_q} == DEST_POS);
    fail       = fail_q;
    pop        = (state_q == S_DRAIN) & ~empty & (count_q < COUNT_FULL);
    mem_we     = pop;
    mem_waddr  = IW'(count_q);
  end

  // Next-state logic for the replay FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fail_d  = 1'b0;
          count_d = '0;
          row_d   = 4'd0;
          col_d   = 4'd0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!empty) begin
          if (count_q == COUNT_FULL) begin
            // Path longer than the buffer: give up rather than truncate.
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else if (count_q == '0) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          // Last entry popped is the first move of the path.
          idx_d   = IW'(count_q - CW'(1));
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (oob) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else if (accept) begin
          row_d = nxt_row;
          col_d = nxt_col;
          if (idx_q == '0) state_d = S_FIN;
          else             idx_d   = idx_q - IW'(1);
        end
      end
      default: begin
        if ({row_q, col_q} != DEST_POS) fail_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fail_q  <= fail_d;
    end
  end

  // Path buffer: each popped direction lands at the current count.
  always_ff @(posedge clk) begin
    if (mem_we) path_mem_q[mem_waddr] <= dout;
  end

endmodule

// File: doc/path_replay.md
Name: path_replay

Overview:
- Consumes the direction stack left behind by the maze path search after it reports done, and replays the solved path in forward order, from origin (0,0) to the destination cell.
- Drains the LIFO stack into a local buffer, then emits one move per valid/ready handshake with the running row/column/address.
- Checks the replayed path for bounds violations and for reaching DEST_ADDR.

Parameters:
- ADDR_WIDTH, 8, maze cell address width; row = addr[7:4], column = addr[3:0].
- DEST_ADDR, 2**8-1, address the replayed path must end on.
- DEPTH, 256, maximum path length held in the local buffer.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  begin replay; sampled in IDLE only.
- empty  input  1  stack empty flag.
- dout  input  2  stack top direction; valid whenever empty=0.
- pop  output  1  remove stack top this cycle.
- move_valid  output  1  move_dir/row/colomn/addr hold a move.
- move_ready  input  1  downstream accepts the move.
- move_dir  output  2  direction of the current move.
- row  output  4  row after applying the current move.
- colomn  output  4  column after applying the current move.
- addr  output  ADDR_WIDTH  row*16+colomn after applying the current move.
- busy  output  1  high in DRAIN and EMIT.
- done  output  1  one-cycle pulse on successful replay.
- fail  output  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Direction encoding: 0 = colomn+1, 1 = row+1, 2 = colomn-1, 3 = row-1.
- Reset (rst=0, any state, asynchronous): state=IDLE, count=0, idx=0, internal position=(0,0).
  - All outputs 0.
  - The stack is not restored; any stack entries already popped are lost.
- FSM states: IDLE, DRAIN, EMIT, FIN.
- IDLE:
  - start=1: clear fail, count=0, position=(0,0), go to DRAIN. busy rises the next cycle.
  - start is ignored in every other state.
- DRAIN:
  - pop is combinational: pop = (state==DRAIN) & !empty & (count<DEPTH).
  - On each edge with pop=1: buf[count] <= dout, count++. Throughput is one entry per cycle.
  - empty=1 with count==0: fail=1, go to IDLE (empty path can never reach DEST_ADDR).
  - empty=1 with count>0: idx <= count-1, go to EMIT. move_valid rises the cycle after empty is seen.
  - empty=0 with count==DEPTH: overflow; fail=1, go to IDLE. No pop is issued that cycle.
- EMIT:
  - move_valid=1 and move_dir=buf[idx]. First popped is the last move, so emission runs idx = count-1 down to 0.
  - row/colomn/addr show the position after the current move: combinational from the registered position plus move_dir.
  - Outputs stay stable while move_valid=1 and move_ready=0.
  - On move_valid & move_ready: the position register takes the new position, idx--.
  - Bounds: if the next row or colomn would go outside 0..15, fail=1 and go to IDLE the same cycle. The move is not handshaken: move_valid is forced 0 that cycle and row/colomn/addr do not wrap.
  - Acceptance with idx==0: go to FIN.
- FIN (one cycle, then IDLE):
  - Position == DEST_ADDR: done=1 for exactly one cycle.
  - Otherwise: fail=1.
- done and fail are never high in the same cycle.
- busy=0 in FIN and IDLE.
- After FIN, row/colomn/addr hold the last position until the next start.
- Arithmetic: position is 4+4 bits; addr = {row,colomn}. No carry between fields.

Test Plan:
- Stack preloaded (bottom→top) with 15×dir0 then 15×dir1, start, move_ready=1:
  - exactly 30 pops on 30 consecutive cycles;
  - 30 moves: the first 15 have move_dir=0 and addr=1..15, the last 15 have move_dir=1 and addr ending 255;
  - done pulse 1 cycle, fail=0.
- Same stack, move_ready toggled 1/0 every cycle: 30 accepted moves, outputs stable during every ready=0 cycle, done asserted.
- Stack [dir1, dir0, dir0]: moves (1,0)→addr 16, (1,1)→17, (1,2)→18; FIN gives fail=1, done=0.
- start with empty=1: no pop, fail=1 two cycles after start, busy low afterwards.
- Stack with single entry dir3: bounds error on the first move, move_valid never 1, fail=1.
- rst driven low mid-EMIT (after 5 moves), not aligned to clk:
  - all outputs 0 immediately;
  - after release, a new start with empty=1 gives fail=1, proving the state was cleared.
